// File: rtl/sead_ecc_reg.sv
// SEC-DED protected register with bit interleaving across NSEG Hamming
// segments, idle-cycle scrubbing, error injection and error accounting.
module sead_ecc_reg #(
    parameter int unsigned           DATA_W    = 32,
    parameter int unsigned           SEG_W     = 11,
    parameter logic [DATA_W-1:0]     RESET_VAL = '0,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inj_en,
    input  logic [DATA_W-1:0] inj_mask,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_out,
    output logic              ce_pulse,
    output logic              double_error_flag,
    output logic [CNT_W-1:0]  ce_count
);

    // Smallest P with 2^P >= m + P + 1.
    function automatic int unsigned calc_p(input int unsigned m);
        int unsigned res;
        logic        found;
        res   = 1;
        found = 1'b0;
        for (int unsigned p = 1; p < 31; p++) begin
            if (!found && ((32'd1 << p) >= m + p + 1)) begin
                res   = p;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    localparam int unsigned NSEG  = (DATA_W + SEG_W - 1) / SEG_W;
    localparam int unsigned P     = calc_p(SEG_W);
    localparam int unsigned NPOS  = SEG_W + P;
    localparam int unsigned CHK_W = NSEG * (P + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ce;
        logic              ue;
    } dec_t;

    // Per segment: bits [P-1:0] are Hamming checks, bit P is overall parity.
    // Data slot j of segment s is data bit s + j*NSEG; missing slots read as 0.
    function automatic logic [CHK_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        logic [P-1:0]     chk;
        logic             par;
        int unsigned      slot;
        int unsigned      idx;
        c = '0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            chk  = '0;
            par  = 1'b0;
            slot = 0;
            for (int unsigned pos = 1; pos <= NPOS; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    idx = s + slot * NSEG;
                    if (idx < DATA_W && d[idx]) begin
                        chk = chk ^ pos[P-1:0];
                        par = ~par;
                    end
                    slot++;
                end
            end
            c[s*(P+1) +: (P+1)] = {par ^ (^chk), chk};
        end
        return c;
    endfunction

    // Syndrome starts from the stored checks and absorbs recomputed ones;
    // mismatch parity covers the whole received codeword (data, checks, parity).
    function automatic dec_t decode(input logic [DATA_W-1:0] d,
                                    input logic [CHK_W-1:0]  c);
        dec_t         r;
        logic [P-1:0] syn;
        logic         pmis;
        logic         any_ce;
        int unsigned  slot;
        int unsigned  idx;
        int unsigned  syn_i;
        r.data = d;
        r.ce   = 1'b0;
        r.ue   = 1'b0;
        any_ce = 1'b0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            syn  = c[s*(P+1) +: P];
            pmis = c[s*(P+1) + P] ^ (^c[s*(P+1) +: P]);
            slot = 0;
            for (int unsigned pos = 1; pos <= NPOS; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    idx = s + slot * NSEG;
                    if (idx < DATA_W && d[idx]) begin
                        syn  = syn ^ pos[P-1:0];
                        pmis = ~pmis;
                    end
                    slot++;
                end
            end
            syn_i = 32'(syn);
            if (syn_i != 0 || pmis) begin
                if (pmis && syn_i <= NPOS) begin
                    any_ce = 1'b1;
                    slot   = 0;
                    for (int unsigned pos = 1; pos <= NPOS; pos++) begin
                        if ((pos & (pos - 1)) != 0) begin
                            idx = s + slot * NSEG;
                            if (pos == syn_i && idx < DATA_W) begin
                                r.data[idx] = ~d[idx];
                            end
                            slot++;
                        end
                    end
                end else begin
                    r.ue = 1'b1;
                end
            end
        end
        r.ce = any_ce & ~r.ue;
        return r;
    endfunction

    localparam logic [CHK_W-1:0] CHK_RST = encode(RESET_VAL);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CHK_W-1:0]  chk_q, chk_d;
    logic              ce_pulse_q, ce_pulse_d;
    logic              due_q, due_d;
    logic [CNT_W-1:0]  ce_count_q, ce_count_d;
    dec_t              dec;

    // Combinational decode of the stored codewords.
    always_comb begin
        dec = decode(data_q, chk_q);
    end

    // Write action priority (load, inject, scrub, hold) and error accounting.
    always_comb begin
        data_d     = data_q;
        chk_d      = chk_q;
        ce_pulse_d = dec.ce;
        due_d      = due_q;
        ce_count_d = ce_count_q;

        if (load_en) begin
            data_d = data_in;
            chk_d  = encode(data_in);
        end else if (inj_en) begin
            data_d = data_q ^ inj_mask;
        end else if (dec.ce) begin
            data_d = dec.data;
            chk_d  = encode(dec.data);
        end

        // Same-cycle events override clear_err.
        if (clear_err) begin
            due_d      = 1'b0;
            ce_count_d = '0;
        end
        if (dec.ue) begin
            due_d = 1'b1;
        end
        if (dec.ce) begin
            if (clear_err) begin
                ce_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (ce_count_q != '1) begin
                ce_count_d = ce_count_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q     <= RESET_VAL;
            chk_q      <= CHK_RST;
            ce_pulse_q <= 1'b0;
            due_q      <= 1'b0;
            ce_count_q <= '0;
        end else begin
            data_q     <= data_d;
            chk_q      <= chk_d;
            ce_pulse_q <= ce_pulse_d;
            due_q      <= due_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign data_out          = dec.data;
    assign ce_pulse          = ce_pulse_q;
    assign double_error_flag = due_q;
    assign ce_count          = ce_count_q;

endmodule

// File: tb/tb_sead_ecc_reg.sv
// Directed bench for sead_ecc_reg: a 32-bit instance pair (CNT_W 8 and 2,
// sharing stimulus) and a 16-bit, 4-segment instance.
module tb_sead_ecc_reg;

    logic        clk;
    logic        rst_a, load_a, inj_a, clr_a;
    logic [31:0] din_a, mask_a;
    logic [31:0] dout0, dout1;
    logic        pulse0, pulse1, flag0, flag1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    logic        rst_b, load_b, inj_b, clr_b;
    logic [15:0] din_b, mask_b;
    logic [15:0] dout2;
    logic        pulse2, flag2;
    logic [7:0]  cnt2;

    int checks = 0;
    int errors = 0;

    sead_ecc_reg #(.DATA_W(32), .SEG_W(11), .RESET_VAL(32'h0000_1000), .CNT_W(8)) dut0 (
        .clk(clk), .rstN(rst_a), .load_en(load_a), .data_in(din_a), .inj_en(inj_a),
        .inj_mask(mask_a), .clear_err(clr_a), .data_out(dout0), .ce_pulse(pulse0),
        .double_error_flag(flag0), .ce_count(cnt0));

    sead_ecc_reg #(.DATA_W(32), .SEG_W(11), .RESET_VAL(32'h0000_1000), .CNT_W(2)) dut1 (
        .clk(clk), .rstN(rst_a), .load_en(load_a), .data_in(din_a), .inj_en(inj_a),
        .inj_mask(mask_a), .clear_err(clr_a), .data_out(dout1), .ce_pulse(pulse1),
        .double_error_flag(flag1), .ce_count(cnt1));

    sead_ecc_reg #(.DATA_W(16), .SEG_W(4), .RESET_VAL(16'hA5C3), .CNT_W(8)) dut2 (
        .clk(clk), .rstN(rst_b), .load_en(load_b), .data_in(din_b), .inj_en(inj_b),
        .inj_mask(mask_b), .clear_err(clr_b), .data_out(dout2), .ce_pulse(pulse2),
        .double_error_flag(flag2), .ce_count(cnt2));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        load_a = 0; inj_a = 0; clr_a = 0; din_a = '0; mask_a = '0;
        load_b = 0; inj_b = 0; clr_b = 0; din_b = '0; mask_b = '0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        checks++; if (dout0 !== 32'h0000_1000) begin errors++; $display("FAIL reset_dout0: got %h exp %h", dout0, 32'h0000_1000); end
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL reset_pulse0: got %b exp 0", pulse0); end
        checks++; if (flag0 !== 1'b0) begin errors++; $display("FAIL reset_flag0: got %b exp 0", flag0); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt0: got %0d exp 0", cnt0); end
        checks++; if (dout1 !== 32'h0000_1000) begin errors++; $display("FAIL reset_dout1: got %h exp %h", dout1, 32'h0000_1000); end
        checks++; if (dout2 !== 16'hA5C3) begin errors++; $display("FAIL reset_dout2: got %h exp a5c3", dout2); end
        checks++; if (cnt2 !== 8'd0 || flag2 !== 1'b0 || pulse2 !== 1'b0) begin errors++; $display("FAIL reset_flags2: got cnt %0d flag %b pulse %b exp 0 0 0", cnt2, flag2, pulse2); end
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        step();
    endtask

    task automatic test_load();
        din_a = 32'hDEADBEEF; load_a = 1'b1;
        step();
        load_a = 1'b0;
        checks++; if (dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_dout: got %h exp deadbeef", dout0); end
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL load_pulse: got %b exp 0", pulse0); end
        step();
        checks++; if (pulse0 !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("FAIL load_quiet: got pulse %b cnt %0d exp 0 0", pulse0, cnt0); end
    endtask

    task automatic test_single_inject();
        mask_a = 32'h1; inj_a = 1'b1;
        step();
        inj_a = 1'b0;
        checks++; if (dut0.data_q !== 32'hDEADBEEE) begin errors++; $display("FAIL single_stored_flip: got %h exp deadbeee", dut0.data_q); end
        checks++; if (dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_corrected: got %h exp deadbeef", dout0); end
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL single_pulse_early: got %b exp 0", pulse0); end
        step();
        checks++; if (pulse0 !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b exp 1", pulse0); end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", cnt0); end
        checks++; if (dut0.data_q !== 32'hDEADBEEF) begin errors++; $display("FAIL single_scrubbed: got %h exp deadbeef", dut0.data_q); end
        checks++; if (dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dout_after: got %h exp deadbeef", dout0); end
        step();
        checks++; if (pulse0 !== 1'b0 || cnt0 !== 8'd1) begin errors++; $display("FAIL single_settled: got pulse %b cnt %0d exp 0 1", pulse0, cnt0); end
    endtask

    task automatic test_two_segments();
        mask_a = 32'h3; inj_a = 1'b1;
        step();
        inj_a = 1'b0;
        checks++; if (dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL twoseg_corrected: got %h exp deadbeef", dout0); end
        step();
        checks++; if (pulse0 !== 1'b1 || cnt0 !== 8'd2) begin errors++; $display("FAIL twoseg_count: got pulse %b cnt %0d exp 1 2", pulse0, cnt0); end
        checks++; if (flag0 !== 1'b0) begin errors++; $display("FAIL twoseg_flag: got %b exp 0", flag0); end
        checks++; if (dut0.data_q !== 32'hDEADBEEF) begin errors++; $display("FAIL twoseg_scrubbed: got %h exp deadbeef", dut0.data_q); end
        step();
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL twoseg_pulse_end: got %b exp 0", pulse0); end
    endtask

    task automatic test_back_to_back();
        din_a = 32'hCAFEF00D; load_a = 1'b1; mask_a = 32'hFF; inj_a = 1'b1;
        step();
        load_a = 1'b0; inj_a = 1'b0;
        checks++; if (dut0.data_q !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_load_wins: got %h exp cafef00d", dut0.data_q); end
        checks++; if (dout0 !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_dout: got %h exp cafef00d", dout0); end
    endtask

    task automatic test_ce_with_inj();
        mask_a = 32'h1; inj_a = 1'b1;
        step();
        mask_a = 32'h10;
        step();
        inj_a = 1'b0;
        checks++; if (dut0.data_q !== (32'hCAFEF00D ^ 32'h11)) begin errors++; $display("FAIL ceinj_not_scrubbed: got %h exp %h", dut0.data_q, 32'hCAFEF00D ^ 32'h11); end
        checks++; if (pulse0 !== 1'b1 || cnt0 !== 8'd3) begin errors++; $display("FAIL ceinj_counted: got pulse %b cnt %0d exp 1 3", pulse0, cnt0); end
        checks++; if (dout0 !== 32'hCAFEF00D) begin errors++; $display("FAIL ceinj_dout: got %h exp cafef00d", dout0); end
        step();
        checks++; if (dut0.data_q !== 32'hCAFEF00D || cnt0 !== 8'd4) begin errors++; $display("FAIL ceinj_scrub: got %h cnt %0d exp cafef00d 4", dut0.data_q, cnt0); end
        step();
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL ceinj_pulse_end: got %b exp 0", pulse0); end
    endtask

    task automatic test_double();
        mask_a = 32'h9; inj_a = 1'b1;
        step();
        inj_a = 1'b0;
        checks++; if (dout0 !== (32'hCAFEF00D ^ 32'h9)) begin errors++; $display("FAIL double_passthru: got %h exp %h", dout0, 32'hCAFEF00D ^ 32'h9); end
        checks++; if (flag0 !== 1'b0) begin errors++; $display("FAIL double_flag_early: got %b exp 0", flag0); end
        step();
        checks++; if (flag0 !== 1'b1) begin errors++; $display("FAIL double_flag: got %b exp 1", flag0); end
        checks++; if (pulse0 !== 1'b0 || cnt0 !== 8'd4) begin errors++; $display("FAIL double_no_ce: got pulse %b cnt %0d exp 0 4", pulse0, cnt0); end
        step();
        checks++; if (flag0 !== 1'b1 || dut0.data_q !== (32'hCAFEF00D ^ 32'h9)) begin errors++; $display("FAIL double_persist: got flag %b data %h", flag0, dut0.data_q); end
        din_a = 32'h12345678; load_a = 1'b1;
        step();
        load_a = 1'b0;
        checks++; if (dout0 !== 32'h12345678) begin errors++; $display("FAIL double_reload: got %h exp 12345678", dout0); end
        step();
        checks++; if (flag0 !== 1'b1) begin errors++; $display("FAIL double_sticky: got %b exp 1", flag0); end
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        checks++; if (flag0 !== 1'b0 || cnt0 !== 8'd0) begin errors++; $display("FAIL double_clear: got flag %b cnt %0d exp 0 0", flag0, cnt0); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mask_a = 32'h1 << (k * 5); inj_a = 1'b1;
            step();
            inj_a = 1'b0;
            step();
            exp_sat = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            checks++; if (cnt1 !== exp_sat) begin errors++; $display("FAIL sat_cnt1[%0d]: got %0d exp %0d", k, cnt1, exp_sat); end
            checks++; if (cnt0 !== 8'(k + 1)) begin errors++; $display("FAIL sat_cnt0[%0d]: got %0d exp %0d", k, cnt0, k + 1); end
        end
        mask_a = 32'h8000_0000; inj_a = 1'b1;
        step();
        inj_a = 1'b0; clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        checks++; if (cnt1 !== 2'd1 || cnt0 !== 8'd1) begin errors++; $display("FAIL sat_clear_ce: got cnt1 %0d cnt0 %0d exp 1 1", cnt1, cnt0); end
        checks++; if (pulse1 !== 1'b1 || dout1 !== 32'h0000_1000) begin errors++; $display("FAIL sat_pulse: got pulse %b dout %h exp 1 00001000", pulse1, dout1); end
    endtask

    task automatic test_exhaustive16();
        for (int b = 0; b < 16; b++) begin
            mask_b = 16'h1 << b; inj_b = 1'b1;
            step();
            inj_b = 1'b0;
            checks++; if (dout2 !== 16'hA5C3) begin errors++; $display("FAIL ex16_corr[%0d]: got %h exp a5c3", b, dout2); end
            checks++; if (dut2.data_q !== (16'hA5C3 ^ (16'h1 << b))) begin errors++; $display("FAIL ex16_flip[%0d]: got %h", b, dut2.data_q); end
            step();
            checks++; if (dut2.data_q !== 16'hA5C3 || pulse2 !== 1'b1) begin errors++; $display("FAIL ex16_scrub[%0d]: got %h pulse %b exp a5c3 1", b, dut2.data_q, pulse2); end
            checks++; if (cnt2 !== 8'(b + 1) || flag2 !== 1'b0) begin errors++; $display("FAIL ex16_cnt[%0d]: got %0d flag %b exp %0d 0", b, cnt2, flag2, b + 1); end
        end
    endtask

    task automatic test_reset_mid_scrub();
        mask_b = 16'h20; inj_b = 1'b1;
        step();
        inj_b = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++; if (dut2.data_q !== 16'hA5C3 || dout2 !== 16'hA5C3) begin errors++; $display("FAIL midrst_data: got %h / %h exp a5c3", dut2.data_q, dout2); end
        checks++; if (cnt2 !== 8'd0 || pulse2 !== 1'b0 || flag2 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got cnt %0d pulse %b flag %b exp 0 0 0", cnt2, pulse2, flag2); end
        rst_b = 1'b1;
        step();
        step();
        checks++; if (cnt2 !== 8'd0 || pulse2 !== 1'b0) begin errors++; $display("FAIL midrst_clean: got cnt %0d pulse %b exp 0 0", cnt2, pulse2); end
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_load();
        test_single_inject();
        test_two_segments();
        test_back_to_back();
        test_ce_with_inj();
        test_double();
        test_saturation();
        test_exhaustive16();
        test_reset_mid_scrub();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sead_ecc_reg.md
# sead_ecc_reg

Parametrised SEC-DED protected register with bit interleaving, automatic scrubbing, error injection and error accounting. It generalises the protected program-counter register to any data width and codeword size. Any architectural register in the SEAD core (PC, CSRs, pipeline state) can instantiate it. Stored data is encoded on write and decoded combinationally on read. Correctable errors are written back (scrubbed) on the next idle cycle, and uncorrectable errors raise a sticky flag.

## Interface
- DATA_W, 32, protected data width (>= 2)
- SEG_W, 11, data bits per SEC-DED codeword (>= 2)
- RESET_VAL, 0, DATA_W-bit value held after reset
- CNT_W, 8, width of the saturating corrected-error counter
- Derived: NSEG = ceil(DATA_W/SEG_W); P = smallest integer with 2^P >= SEG_W+P+1; check bits per segment = P+1; total check width CHK_W = NSEG*(P+1)

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  asynchronous active-low reset
- load_en  in  1  write data_in this cycle
- data_in  in  DATA_W  new value
- inj_en  in  1  error injection strobe (verification/fault campaigns)
- inj_mask  in  DATA_W  bits of stored data to flip when inj_en
- clear_err  in  1  clear double_error_flag and ce_count
- data_out  out  DATA_W  corrected stored value (combinational from storage)
- ce_pulse  out  1  registered; 1 for one cycle after a cycle with a correctable error
- double_error_flag  out  1  registered, sticky uncorrectable-error flag
- ce_count  out  CNT_W  saturating count of cycles with a correctable error

## Operation
- Storage: data_q[DATA_W], chk_q[CHK_W]; no other architectural state.
- Interleave: data bit i goes to segment i mod NSEG, slot i / NSEG. Unused slots of the last segments are constant 0, neither stored nor flipped.
- Per-segment Hamming layout: codeword positions 1..SEG_W+P. Powers of two hold check bits. Data slots fill the remaining positions in ascending order (slot 0 at position 3). Check bit k = XOR of data at positions with bit k set. Overall parity = XOR of all data slots and the P check bits.
- Decode per segment: syndrome = recomputed check XOR stored check; pmis = recomputed overall parity XOR stored overall parity.
  - syn=0, pmis=0: clean.
  - syn!=0, pmis=1: correctable. Flip the data slot at position syn. If syn is a check position, data is unchanged.
  - syn=0, pmis=1: correctable. The error is in the overall-parity bit; data is unchanged.
  - syn!=0, pmis=0: uncorrectable. Data passes through uncorrected.
  - syn pointing past the last valid position with pmis=1 is treated as uncorrectable.
- ce_now = any segment correctable and no segment uncorrectable. ue_now = any segment uncorrectable.
- Write priority per cycle (exactly one action):
  1. load_en: data_q <= data_in, chk_q <= encode(data_in).
  2. else inj_en: data_q <= data_q ^ inj_mask; chk_q unchanged.
  3. else ce_now: scrub. data_q <= data_out, chk_q <= encode(data_out).
  4. else: hold.
- Accounting, evaluated every cycle regardless of the write action:
  - ce_pulse <= ce_now.
  - ce_count increments by 1 when ce_now and saturates at 2^CNT_W-1.
  - double_error_flag <= 1 when ue_now.
  - clear_err zeroes ce_count and double_error_flag. An event in the same cycle wins: the flag stays 1, and ce_count becomes 1 if ce_now.

## Timing
- Reset (async assert, no clk needed):
  - data_q = RESET_VAL, chk_q = encode(RESET_VAL)
  - data_out = RESET_VAL
  - ce_pulse = 0, double_error_flag = 0, ce_count = 0
- data_out has zero-cycle latency from storage. A new load is visible on data_out the cycle after load_en.
- Injection is visible in decode the cycle after inj_en. Correction of data_out occurs in that same cycle.
- A scrub completes one cycle after detection. Storage is clean from then on unless another event occurs.
- A correctable error coinciding with load_en or inj_en is not scrubbed; it is still counted and pulsed. The load overwrites it; an injection leaves it to be scrubbed or re-evaluated next cycle.
- Uncorrectable errors are never scrubbed. They persist until load_en or reset.
- Reset mid-scrub or mid-injection aborts the action; all state returns to reset values.

## Test plan
- Reset with RESET_VAL=0x0000_1000 -> data_out=0x1000, all flags 0, ce_count=0. Load 0xDEADBEEF -> data_out=0xDEADBEEF next cycle, ce_pulse stays 0.
- Load 0xDEADBEEF, then inj_mask=0x0000_0001 -> data_out stays 0xDEADBEEF every cycle. ce_pulse=1 for exactly one cycle, ce_count=1. Cycle after scrub: no error, storage bit restored.
- inj_mask=0x0000_0003 (bits in different segments) -> both corrected, data_out unchanged, ce_count +1 (one per cycle, not per bit), double_error_flag=0.
- inj_mask=0x0000_0009 (bits 0 and 3, both segment 0 for NSEG=3) -> double_error_flag=1 next cycle and stays 1. Next load of 0x1234_5678 clears the error condition; the flag stays set until clear_err.
- CNT_W=2: five single-bit injections, each scrubbed -> ce_count 1,2,3,3,3. clear_err coincident with a sixth ce_now -> ce_count=1.
- DATA_W=16, SEG_W=4 (NSEG=4, P=3): exhaustive single-bit injection over all 16 bits -> all corrected. Assert rstN low during a scrub cycle -> reset values immediately.
